// File: rtl/amber128_pkg.sv
// Shared types and constants for the amber128 data-memory path.
package amber128_pkg;

  localparam int unsigned C_XLEN           = 128;
  localparam int unsigned C_ADDR_W         = 64;
  localparam int unsigned C_DMEM_MAX_RETRY = 15;

  typedef enum logic [1:0] {
    IDLE,
    ISSUE,
    WAIT
  } arb_state_e;

  // Access captured from the granted requester
  typedef struct packed {
    logic                we;
    logic [C_ADDR_W-1:0] addr;
    logic [C_XLEN-1:0]   wdata;
  } dmem_req_t;

endpackage

// File: rtl/amber128_rr_arb2.sv
// Two-way round-robin grant; on a tie the port not granted last wins.
module amber128_rr_arb2 (
  input  logic       clk_i,
  input  logic       rst_i,
  input  logic [1:0] req,
  input  logic       advance,
  output logic [1:0] gnt
);

  logic prio_q;  // 1: port 1 wins a tie

  always_comb begin
    gnt = 2'b00;
    unique case (req)
      2'b01:   gnt = 2'b01;
      2'b10:   gnt = 2'b10;
      2'b11:   gnt = prio_q ? 2'b10 : 2'b01;
      default: gnt = 2'b00;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      prio_q <= 1'b0;
    end else if (advance && (gnt != 2'b00)) begin
      prio_q <= gnt[0];
    end
  end

endmodule

// File: rtl/amber128_dmem_arbiter.sv
// Shares the dmem port between two requesters, one access outstanding,
// re-issuing stalled accesses and trapping after MAX_RETRY re-issues.
module amber128_dmem_arbiter
  import amber128_pkg::*;
#(
  parameter int unsigned MAX_RETRY = C_DMEM_MAX_RETRY
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic [1:0]               p_valid_i,
  output logic [1:0]               p_ready_o,
  input  logic [1:0]               p_we_i,
  input  logic [1:0][C_ADDR_W-1:0] p_addr_i,
  input  logic [1:0][C_XLEN-1:0]   p_wdata_i,
  output logic [1:0]               p_rsp_valid_o,
  output logic [C_XLEN-1:0]        p_rdata_o,
  output logic                     p_trap_o,
  output logic                     mem_req_o,
  output logic                     mem_we_o,
  output logic [C_ADDR_W-1:0]      mem_addr_o,
  output logic [C_XLEN-1:0]        mem_wdata_o,
  input  logic [C_XLEN-1:0]        mem_rdata_i,
  input  logic                     mem_ready_i,
  input  logic                     mem_trap_i
);

  localparam int unsigned CNT_W = $clog2(MAX_RETRY + 1);

  arb_state_e       state_q, state_d;
  dmem_req_t        req_q;
  logic             id_q;
  logic [CNT_W-1:0] retry_q, retry_d;
  logic             mem_req_q;
  logic [1:0]       rsp_valid_q;
  logic [C_XLEN-1:0] rdata_q;
  logic             trap_q;

  logic       is_idle;
  logic [1:0] gnt;
  logic       accept;
  logic       rsp_fire;
  logic       rsp_timeout;
  logic       sel;

  assign is_idle = (state_q == IDLE);
  assign sel     = gnt[1];

  // Requests are only visible to the arbiter while idle
  amber128_rr_arb2 u_rr (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (is_idle ? p_valid_i : 2'b00),
    .advance (is_idle),
    .gnt     (gnt)
  );

  always_comb begin
    state_d     = state_q;
    retry_d     = retry_q;
    accept      = 1'b0;
    rsp_fire    = 1'b0;
    rsp_timeout = 1'b0;
    unique case (state_q)
      IDLE: begin
        if (gnt != 2'b00) begin
          accept  = 1'b1;
          retry_d = '0;
          state_d = ISSUE;
        end
      end
      ISSUE: state_d = WAIT;
      WAIT: begin
        if (mem_ready_i) begin
          rsp_fire = 1'b1;
          state_d  = IDLE;
        end else if (retry_q < CNT_W'(MAX_RETRY)) begin
          retry_d = retry_q + CNT_W'(1);
          state_d = ISSUE;
        end else begin
          rsp_fire    = 1'b1;
          rsp_timeout = 1'b1;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q     <= IDLE;
      retry_q     <= '0;
      mem_req_q   <= 1'b0;
      rsp_valid_q <= 2'b00;
    end else begin
      state_q     <= state_d;
      retry_q     <= retry_d;
      mem_req_q   <= (state_d == ISSUE);
      rsp_valid_q <= rsp_fire ? (id_q ? 2'b10 : 2'b01) : 2'b00;
    end
  end

  // Captured access fields and held response data
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      req_q   <= '0;
      id_q    <= 1'b0;
      rdata_q <= '0;
      trap_q  <= 1'b0;
    end else begin
      if (accept) begin
        id_q  <= sel;
        req_q <= '{we: p_we_i[sel], addr: p_addr_i[sel], wdata: p_wdata_i[sel]};
      end
      if (rsp_fire) begin
        rdata_q <= rsp_timeout ? '0 : mem_rdata_i;
        trap_q  <= rsp_timeout | mem_trap_i;
      end
    end
  end

  assign p_ready_o     = gnt;
  assign p_rsp_valid_o = rsp_valid_q;
  assign p_rdata_o     = rdata_q;
  assign p_trap_o      = trap_q;
  assign mem_req_o     = mem_req_q;
  assign mem_we_o      = req_q.we;
  assign mem_addr_o    = req_q.addr;
  assign mem_wdata_o   = req_q.wdata;

endmodule

// File: tb/tb_amber128_dmem_arbiter.sv
// Directed bench for amber128_dmem_arbiter with a small behavioural dmem.
module tb_amber128_dmem_arbiter;
  import amber128_pkg::*;

  localparam logic [C_XLEN-1:0] DA5 = {16{8'hA5}};
  localparam logic [C_XLEN-1:0] DB  = 128'h0123456789ABCDEF_FEDCBA9876543210;

  logic clk = 1'b0;
  logic rst;
  logic [1:0]               p_valid, q_valid, p_we;
  logic [1:0][63:0]         p_addr;
  logic [1:0][C_XLEN-1:0]   p_wdata;

  logic [1:0]        p_ready, p_rsp;
  logic [C_XLEN-1:0] p_rdata;
  logic              p_trap, mem_req, mem_we;
  logic [63:0]       mem_addr;
  logic [C_XLEN-1:0] mem_wdata;
  logic              mem_ready;
  logic              mdl_ready = 1'b0;
  logic              mdl_trap  = 1'b0;
  logic [C_XLEN-1:0] mdl_rdata = '0;
  logic              force_rdy;

  logic [1:0]        q_ready, q_rsp;
  logic [C_XLEN-1:0] q_rdata;
  logic              q_trap, q_mem_req, q_mem_we;
  logic [63:0]       q_mem_addr;
  logic [C_XLEN-1:0] q_mem_wdata;

  int errs = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign mem_ready = mdl_ready | force_rdy;

  amber128_dmem_arbiter dut (
    .clk_i(clk), .rst_i(rst),
    .p_valid_i(p_valid), .p_ready_o(p_ready), .p_we_i(p_we),
    .p_addr_i(p_addr), .p_wdata_i(p_wdata),
    .p_rsp_valid_o(p_rsp), .p_rdata_o(p_rdata), .p_trap_o(p_trap),
    .mem_req_o(mem_req), .mem_we_o(mem_we), .mem_addr_o(mem_addr),
    .mem_wdata_o(mem_wdata), .mem_rdata_i(mdl_rdata),
    .mem_ready_i(mem_ready), .mem_trap_i(mdl_trap)
  );

  // Second instance sees a dmem that never answers
  amber128_dmem_arbiter #(.MAX_RETRY(2)) dut2 (
    .clk_i(clk), .rst_i(rst),
    .p_valid_i(q_valid), .p_ready_o(q_ready), .p_we_i(p_we),
    .p_addr_i(p_addr), .p_wdata_i(p_wdata),
    .p_rsp_valid_o(q_rsp), .p_rdata_o(q_rdata), .p_trap_o(q_trap),
    .mem_req_o(q_mem_req), .mem_we_o(q_mem_we), .mem_addr_o(q_mem_addr),
    .mem_wdata_o(q_mem_wdata), .mem_rdata_i({C_XLEN{1'b1}}),
    .mem_ready_i(1'b0), .mem_trap_i(1'b0)
  );

  // dmem model: answers the cycle after a request, traps on non-16B-aligned
  // addresses, and ignores the first requests up to stall_until.
  int unsigned req_seen = 0;
  int unsigned stall_until = 0;
  logic [C_XLEN-1:0] mem [16];

  always @(posedge clk) begin
    if (mem_req) begin
      req_seen <= req_seen + 1;
      if (req_seen < stall_until) begin
        mdl_ready <= 1'b0;
        mdl_trap  <= 1'b0;
      end else begin
        mdl_ready <= 1'b1;
        if (mem_addr[3:0] != 4'h0) begin
          mdl_trap  <= 1'b1;
          mdl_rdata <= '0;
        end else begin
          mdl_trap  <= 1'b0;
          mdl_rdata <= mem_we ? '0 : mem[mem_addr[7:4]];
          if (mem_we) mem[mem_addr[7:4]] <= mem_wdata;
        end
      end
    end else begin
      mdl_ready <= 1'b0;
      mdl_trap  <= 1'b0;
    end
  end

  task automatic chk(input string name, input logic [C_XLEN-1:0] act,
                     input logic [C_XLEN-1:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_zero(input string t);
    chk({t, " p_ready"}, C_XLEN'(p_ready), '0);
    chk({t, " p_rsp"}, C_XLEN'(p_rsp), '0);
    chk({t, " p_rdata"}, p_rdata, '0);
    chk({t, " p_trap"}, C_XLEN'(p_trap), '0);
    chk({t, " mem_req"}, C_XLEN'(mem_req), '0);
    chk({t, " mem_we"}, C_XLEN'(mem_we), '0);
    chk({t, " mem_addr"}, C_XLEN'(mem_addr), '0);
    chk({t, " mem_wdata"}, mem_wdata, '0);
  endtask

  // Single uncontended access with cycle-exact latency checks
  task automatic access(input string t, input int port, input logic we,
                        input logic [63:0] addr, input logic [C_XLEN-1:0] wd,
                        input logic [C_XLEN-1:0] exp_rd, input logic exp_trap);
    logic [1:0] oh;
    oh = (port == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    p_valid[port] = 1'b1;
    p_we[port]    = we;
    p_addr[port]  = addr;
    p_wdata[port] = wd;
    #1 chk({t, " ready"}, C_XLEN'(p_ready), C_XLEN'(oh));
    @(negedge clk);
    p_valid = 2'b00;
    chk({t, " req N+1"}, C_XLEN'(mem_req), C_XLEN'(1'b1));
    chk({t, " addr"}, C_XLEN'(mem_addr), C_XLEN'(addr));
    chk({t, " we"}, C_XLEN'(mem_we), C_XLEN'(we));
    if (we) chk({t, " wdata"}, mem_wdata, wd);
    @(negedge clk);
    chk({t, " req N+2"}, C_XLEN'(mem_req), '0);
    chk({t, " rsp N+2"}, C_XLEN'(p_rsp), '0);
    @(negedge clk);
    chk({t, " rsp N+3"}, C_XLEN'(p_rsp), C_XLEN'(oh));
    chk({t, " rdata"}, p_rdata, exp_rd);
    chk({t, " trap"}, C_XLEN'(p_trap), C_XLEN'(exp_trap));
    @(negedge clk);
    chk({t, " rsp N+4"}, C_XLEN'(p_rsp), '0);
  endtask

  typedef struct {
    int                port;
    logic              we;
    logic [63:0]       addr;
    logic [C_XLEN-1:0] wdata;
    logic [C_XLEN-1:0] rdata;
    logic              trap;
  } vec_t;

  vec_t vecs[7];

  initial begin
    int pulses, adj, nrsp, rsp_cyc;
    logic prev;
    logic [C_XLEN-1:0] rd;
    logic [1:0] rsp_seen;
    logic tr;

    vecs[0] = '{0, 1'b1, 64'h20, DA5, '0,  1'b0};
    vecs[1] = '{0, 1'b0, 64'h20, '0,  DA5, 1'b0};
    vecs[2] = '{1, 1'b1, 64'h40, DB,  '0,  1'b0};
    vecs[3] = '{0, 1'b0, 64'h40, '0,  DB,  1'b0};
    vecs[4] = '{1, 1'b0, 64'h8,  '0,  '0,  1'b1};
    vecs[5] = '{1, 1'b1, 64'h28, DB,  '0,  1'b1};
    vecs[6] = '{0, 1'b0, 64'h20, '0,  DA5, 1'b0};

    rst = 1'b1; p_valid = 2'b00; q_valid = 2'b00; p_we = 2'b00;
    p_addr = '0; p_wdata = '0; force_rdy = 1'b0;
    #12 chk_zero("reset");
    chk("reset q_rsp", C_XLEN'(q_rsp), '0);
    chk("reset q_mem_req", C_XLEN'(q_mem_req), '0);
    @(negedge clk);
    rst = 1'b0;

    // Contention: both ports held valid, grants must alternate from port 0
    @(negedge clk);
    p_valid = 2'b11; p_we = 2'b11;
    p_addr[0] = 64'h30; p_addr[1] = 64'h50;
    p_wdata[0] = DB; p_wdata[1] = DA5;
    #1;
    for (int k = 0; k < 4; k++) begin
      logic [1:0] e;
      e = k[0] ? 2'b10 : 2'b01;
      chk($sformatf("contend%0d gnt", k), C_XLEN'(p_ready), C_XLEN'(e));
      @(negedge clk);
      chk($sformatf("contend%0d addr", k), C_XLEN'(mem_addr),
          C_XLEN'(k[0] ? 64'h50 : 64'h30));
      @(negedge clk);
      @(negedge clk);
      chk($sformatf("contend%0d rsp", k), C_XLEN'(p_rsp), C_XLEN'(e));
      if (k == 3) p_valid = 2'b00;
    end

    for (int i = 0; i < 7; i++)
      access($sformatf("vec%0d", i), vecs[i].port, vecs[i].we, vecs[i].addr,
             vecs[i].wdata, vecs[i].rdata, vecs[i].trap);

    // Retry: dmem ignores three issues, answers the fourth
    @(negedge clk);
    stall_until = req_seen + 3;
    p_valid[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 64'h20;
    #1 chk("retry ready", C_XLEN'(p_ready), C_XLEN'(2'b01));
    @(negedge clk);
    p_valid = 2'b00;
    pulses = 0; adj = 0; nrsp = 0; rsp_cyc = 0; prev = 1'b0; rd = '0; tr = 1'b1;
    rsp_seen = 2'b00;
    for (int c = 1; c <= 14; c++) begin
      if (mem_req) begin
        pulses++;
        if (prev) adj++;
      end
      prev = mem_req;
      if (p_rsp != 2'b00) begin
        nrsp++; rsp_cyc = c; rd = p_rdata; tr = p_trap; rsp_seen = p_rsp;
      end
      @(negedge clk);
    end
    chk("retry pulses", C_XLEN'(pulses), C_XLEN'(4));
    chk("retry adjacent", C_XLEN'(adj), '0);
    chk("retry nrsp", C_XLEN'(nrsp), C_XLEN'(1));
    chk("retry rsp cycle", C_XLEN'(rsp_cyc), C_XLEN'(9));
    chk("retry rsp port", C_XLEN'(rsp_seen), C_XLEN'(2'b01));
    chk("retry rdata", rd, DA5);
    chk("retry trap", C_XLEN'(tr), '0);

    // Timeout on the MAX_RETRY=2 instance
    @(negedge clk);
    q_valid[1] = 1'b1; p_we[1] = 1'b0; p_addr[1] = 64'h60;
    #1 chk("tmo ready", C_XLEN'(q_ready), C_XLEN'(2'b10));
    @(negedge clk);
    q_valid = 2'b00;
    pulses = 0; adj = 0; nrsp = 0; rsp_cyc = 0; prev = 1'b0; rd = '1; tr = 1'b0;
    rsp_seen = 2'b00;
    for (int c = 1; c <= 12; c++) begin
      if (q_mem_req) begin
        pulses++;
        if (prev) adj++;
      end
      prev = q_mem_req;
      if (q_rsp != 2'b00) begin
        nrsp++; rsp_cyc = c; rd = q_rdata; tr = q_trap; rsp_seen = q_rsp;
      end
      @(negedge clk);
    end
    chk("tmo pulses", C_XLEN'(pulses), C_XLEN'(3));
    chk("tmo adjacent", C_XLEN'(adj), '0);
    chk("tmo nrsp", C_XLEN'(nrsp), C_XLEN'(1));
    chk("tmo rsp cycle", C_XLEN'(rsp_cyc), C_XLEN'(7));
    chk("tmo rsp port", C_XLEN'(rsp_seen), C_XLEN'(2'b10));
    chk("tmo rdata", rd, '0);
    chk("tmo trap", C_XLEN'(tr), C_XLEN'(1'b1));
    q_valid = 2'b01;
    #1 chk("tmo idle again", C_XLEN'(q_ready), C_XLEN'(2'b01));
    q_valid = 2'b00;

    // A ready pulse while idle must not produce a response
    @(negedge clk);
    force_rdy = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      chk($sformatf("idle ready%0d rsp", c), C_XLEN'(p_rsp), '0);
    end
    force_rdy = 1'b0;

    // Reset in WAIT drops the access; port 1 would otherwise win a tie next
    @(negedge clk);
    p_valid[0] = 1'b1; p_we[0] = 1'b0; p_addr[0] = 64'h40;
    #1 chk("rstmid ready", C_XLEN'(p_ready), C_XLEN'(2'b01));
    @(negedge clk);
    p_valid = 2'b00;
    @(negedge clk);
    rst = 1'b1;
    #1 chk_zero("rstmid");
    @(negedge clk);
    rst = 1'b0;
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      chk($sformatf("rstmid quiet%0d", c), C_XLEN'(p_rsp), '0);
    end
    p_valid = 2'b11;
    #1 chk("rstmid gnt", C_XLEN'(p_ready), C_XLEN'(2'b01));
    p_valid = 2'b00;
    @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule
